// File: rtl/mdu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl_if
// Bundles the request-side handshake (E-stage pipeline <-> issue controller)
// and the multicycle-unit bus (issue controller <-> MULT/DIV unit).
//
// Signals
//   req_valid/req_op/req_a/req_b : MDU-class instruction from the E stage
//   req_ready/stall              : acceptance and pipeline freeze
//   rd_data/rd_valid             : mfhi/mflo return path
//   mdu_start/mdu_op/mdu_a/mdu_b : issue to the multicycle unit
//   mdu_busy/mdu_hi/mdu_lo       : status and results from the unit
//
// Modports
//   slave  : the issue controller
//   master : the surrounding pipeline plus the multicycle unit
// ---------------------------------------------------------------------------
interface mdu_issue_ctrl_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        mdu_start;
    logic [1:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    modport slave (
        input  req_valid, req_op, req_a, req_b, mdu_busy, mdu_hi, mdu_lo,
        output req_ready, stall, rd_data, rd_valid, mdu_start, mdu_op, mdu_a, mdu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, mdu_busy, mdu_hi, mdu_lo,
        input  req_ready, stall, rd_data, rd_valid, mdu_start, mdu_op, mdu_a, mdu_b
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
// Issue controller between the E stage and a multicycle MULT/DIV unit.
// mult/multu/div/divu are latched and issued with a one-cycle mdu_start,
// then the controller waits for mdu_busy to drop and captures HI/LO into
// shadow registers. mthi/mtlo write the shadows directly; mfhi/mflo read
// them back one cycle after acceptance. While an operation is in flight
// every request is stalled.
//
// Parameters
//   TIMEOUT : WAIT cycles before a watchdog abort (watchdog build only)
//
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mdu_issue_ctrl_if.slave (request, return and unit signals)
//   err   : sticky watchdog-abort flag
//
// Build option
//   MDU_WATCHDOG_TIMEOUT_EN : when defined, a WAIT-cycle counter aborts an
//   operation whose unit is still busy after TIMEOUT cycles and sets err.
//   When undefined there is no counter, WAIT is unbounded and err is 0.
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mdu_issue_ctrl_if.slave   bus,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mdu_issue_ctrl: TIMEOUT must be at least 1");
    end

    state_t      state_q, state_d;
    logic        wait_armed_q, wait_armed_d;

    logic        mdu_start_q;
    logic [1:0]  mdu_op_q;
    logic [31:0] mdu_a_q;
    logic [31:0] mdu_b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] rd_data_q;
    logic        rd_valid_q;

    logic        req_ready_s;
    logic        accept_s;
    logic        is_muldiv_s;
    logic        is_mthi_s;
    logic        is_mtlo_s;
    logic        is_mfhi_s;
    logic        is_mflo_s;
    logic        wait_done_s;
    logic        wait_abort_s;

    // Opcode decode and request acceptance
    always_comb begin
        is_muldiv_s = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU) ||
                      (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
        is_mthi_s   = (bus.req_op == OP_MTHI);
        is_mtlo_s   = (bus.req_op == OP_MTLO);
        is_mfhi_s   = (bus.req_op == OP_MFHI);
        is_mflo_s   = (bus.req_op == OP_MFLO);
        // Every opcode, including unused ones, is taken in IDLE so that an
        // unknown code never freezes the pipeline; nothing is taken in reset.
        if (!reset && bus.req_valid && (state_q == ST_IDLE)) begin
            req_ready_s = 1'b1;
        end else begin
            req_ready_s = 1'b0;
        end
        accept_s = req_ready_s;
    end

    // Busy is ignored in the first WAIT cycle: the unit may raise it one
    // cycle after seeing mdu_start, so a low busy there means nothing yet.
    assign wait_done_s = (state_q == ST_WAIT) && wait_armed_q && !bus.mdu_busy;

`ifdef MDU_WATCHDOG_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             err_q;

    // wdog_cnt_q holds the number of WAIT cycles already completed, so the
    // abort fires in the TIMEOUT-th WAIT cycle if the unit is still busy.
    assign wait_abort_s = (state_q == ST_WAIT) && !wait_done_s &&
                          (wdog_cnt_q == CNT_W'(TIMEOUT - 1));

    // Watchdog counter next state: counts consecutive WAIT cycles
    always_comb begin
        if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
            wdog_cnt_d = wdog_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_cnt_d = {CNT_W{1'b0}};
        end
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            if (wait_abort_s) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wait_abort_s = 1'b0;
    assign err          = 1'b0;
`endif

    // FSM next-state logic
    always_comb begin
        state_d      = state_q;
        wait_armed_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_muldiv_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done_s || wait_abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_WAIT;
                    wait_armed_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_armed_q <= wait_armed_d;
        end
    end

    // Issue pulse and latched operands; operands hold until the next issue
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_start_q <= 1'b0;
            mdu_op_q    <= 2'd0;
            mdu_a_q     <= 32'd0;
            mdu_b_q     <= 32'd0;
        end else begin
            mdu_start_q <= accept_s && is_muldiv_s;
            if (accept_s && is_muldiv_s) begin
                // Request codes 1..4 map onto unit codes 0..3.
                mdu_op_q <= bus.req_op[1:0] - 2'd1;
                mdu_a_q  <= bus.req_a;
                mdu_b_q  <= bus.req_b;
            end
        end
    end

    // HI/LO shadows: unit results on completion, mthi/mtlo otherwise.
    // Both cannot happen together because nothing is accepted in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (wait_done_s) begin
            hi_q <= bus.mdu_hi;
            lo_q <= bus.mdu_lo;
        end else if (accept_s && is_mthi_s) begin
            hi_q <= bus.req_a;
        end else if (accept_s && is_mtlo_s) begin
            lo_q <= bus.req_a;
        end
    end

    // mfhi/mflo return path, valid for one cycle after acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= accept_s && (is_mfhi_s || is_mflo_s);
            if (accept_s && is_mfhi_s) begin
                rd_data_q <= hi_q;
            end else if (accept_s && is_mflo_s) begin
                rd_data_q <= lo_q;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.stall     = bus.req_valid && !req_ready_s;
    assign bus.mdu_start = mdu_start_q;
    assign bus.mdu_op    = mdu_op_q;
    assign bus.mdu_a     = mdu_a_q;
    assign bus.mdu_b     = mdu_b_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
// Directed self-checking bench for mdu_issue_ctrl. Inputs change 1 time unit
// after the rising edge and outputs are sampled 1 unit later, well away from
// the next edge. The multicycle unit is played by the bench: it raises
// mdu_busy for a programmed number of cycles and presents hand-computed
// HI/LO only in the cycle busy drops (garbage otherwise).
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

    localparam int unsigned TIMEOUT = 16;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic clk = 1'b0;
    logic reset;
    logic err;
    int   n_checks = 0;
    int   n_errs   = 0;

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = valid;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
    endtask

    // Issue one mult/div, hold an mflo behind it during the operation, then
    // read LO and HI back. Busy covers WAIT cycles s..s+len-1, s=1 (or 2 if
    // late); the unit's results appear in WAIT cycle s+len.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int len, input bit late,
                          input logic [1:0] exp_op, input logic [31:0] res_hi,
                          input logic [31:0] res_lo);
        int s;
        s = late ? 2 : 1;
        drive(1'b1, op, a, b);
        check_val({tag, ".acc_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, ".acc_stall"}, 32'(bus.stall), 32'd0);
        tick();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        bus.mdu_hi = 32'hDEAD_BEEF;
        bus.mdu_lo = 32'hDEAD_BEEF;
        check_val({tag, ".iss_start"}, 32'(bus.mdu_start), 32'd1);
        check_val({tag, ".iss_op"}, 32'(bus.mdu_op), 32'(exp_op));
        check_val({tag, ".iss_a"}, bus.mdu_a, a);
        check_val({tag, ".iss_b"}, bus.mdu_b, b);
        check_val({tag, ".iss_stall"}, 32'(bus.stall), 32'd1);
        for (int k = 1; k <= s + len; k++) begin
            tick();
            bus.mdu_busy = (k >= s) && (k < s + len);
            if (k == s + len) begin
                bus.mdu_hi = res_hi;
                bus.mdu_lo = res_lo;
            end
            #1;
            check_val({tag, ".wait_stall"}, 32'(bus.stall), 32'd1);
            check_val({tag, ".wait_start"}, 32'(bus.mdu_start), 32'd0);
            check_val({tag, ".wait_a"}, bus.mdu_a, a);
        end
        tick();
        bus.mdu_hi = 32'hDEAD_BEEF;
        bus.mdu_lo = 32'hDEAD_BEEF;
        #1;
        check_val({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
        check_val({tag, ".idle_stall"}, 32'(bus.stall), 32'd0);
        tick();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        check_val({tag, ".mflo_valid"}, 32'(bus.rd_valid), 32'd1);
        check_val({tag, ".mflo_data"}, bus.rd_data, res_lo);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val({tag, ".mfhi_valid"}, 32'(bus.rd_valid), 32'd1);
        check_val({tag, ".mfhi_data"}, bus.rd_data, res_hi);
        check_val({tag, ".hold_op"}, 32'(bus.mdu_op), 32'(exp_op));
        check_val({tag, ".hold_b"}, bus.mdu_b, b);
        tick();
        check_val({tag, ".rd_pulse"}, 32'(bus.rd_valid), 32'd0);
        check_val({tag, ".no_start"}, 32'(bus.mdu_start), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.mdu_busy = 1'b0;
        bus.mdu_hi   = 32'd0;
        bus.mdu_lo   = 32'd0;
        drive(1'b1, OP_MULT, 32'h0000_0005, 32'h0000_0006);

        // Reset state, with a request pending
        tick();
        tick();
        check_val("rst.ready", 32'(bus.req_ready), 32'd0);
        check_val("rst.stall", 32'(bus.stall), 32'd1);
        check_val("rst.start", 32'(bus.mdu_start), 32'd0);
        check_val("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        check_val("rst.rd_data", bus.rd_data, 32'd0);
        check_val("rst.err", 32'(err), 32'd0);
        check_val("rst.mdu_a", bus.mdu_a, 32'd0);
        check_val("rst.mdu_b", bus.mdu_b, 32'd0);
        check_val("rst.mdu_op", 32'(bus.mdu_op), 32'd0);
        reset = 1'b0;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        check_val("rst.rel_ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val("rst.hi_zero", bus.rd_data, 32'd0);
        check_val("rst.hi_valid", 32'(bus.rd_valid), 32'd1);

        // Ignored opcodes: accepted, no side effects
        tick();
        drive(1'b1, 4'd0, 32'h1111_1111, 32'd0);
        check_val("ign0.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b1, 4'd9, 32'h2222_2222, 32'd0);
        check_val("ign0.start", 32'(bus.mdu_start), 32'd0);
        check_val("ign0.rd_valid", 32'(bus.rd_valid), 32'd0);
        check_val("ign9.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b1, 4'd15, 32'h3333_3333, 32'd0);
        check_val("ign9.start", 32'(bus.mdu_start), 32'd0);
        check_val("ign15.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val("ign15.start", 32'(bus.mdu_start), 32'd0);
        check_val("ign15.mdu_a", bus.mdu_a, 32'd0);

        // mult -2 * 3 = -6 ; divu 100/7 = 14 r 2
        tick();
        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 10, 1'b0, 2'd3, 32'd2, 32'd14);

        // mthi/mtlo then mfhi/mflo, no unit activity
        drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
        check_val("mthi.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        check_val("mthi.start", 32'(bus.mdu_start), 32'd0);
        check_val("mfhi.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b1, OP_MTLO, 32'hCAFE_F00D, 32'd0);
        check_val("mfhi.data", bus.rd_data, 32'h1234_5678);
        check_val("mfhi.valid", 32'(bus.rd_valid), 32'd1);
        check_val("mfhi.start", 32'(bus.mdu_start), 32'd0);
        tick();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        check_val("mtlo.rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val("mflo.data", bus.rd_data, 32'hCAFE_F00D);
        tick();

        // multu 0x10000 * 0x10000 = 2^32 with busy rising one cycle late
        run_op("late", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 3, 1'b1, 2'd1, 32'd1, 32'd0);

        // Reset in the third WAIT cycle of a div
        drive(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7);
        tick();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        bus.mdu_busy = 1'b1;
        tick();
        tick();
        tick();
        reset        = 1'b1;
        bus.mdu_busy = 1'b0;
        bus.mdu_hi   = 32'h1111_1111;
        bus.mdu_lo   = 32'h2222_2222;
        #1;
        check_val("wrst.ready", 32'(bus.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_val("wrst.idle_ready", 32'(bus.req_ready), 32'd1);
        check_val("wrst.mdu_a", bus.mdu_a, 32'd0);
        check_val("wrst.mdu_op", 32'(bus.mdu_op), 32'd0);
        check_val("wrst.start", 32'(bus.mdu_start), 32'd0);
        tick();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        check_val("wrst.hi", bus.rd_data, 32'd0);
        check_val("wrst.hi_valid", 32'(bus.rd_valid), 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val("wrst.lo", bus.rd_data, 32'd0);
        tick();

        // Busy stuck high
        drive(1'b1, OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        tick();
        drive(1'b1, OP_MULT, 32'd3, 32'd4);
        check_val("wd.acc", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        bus.mdu_busy = 1'b1;
        bus.mdu_hi   = 32'h5555_5555;
        bus.mdu_lo   = 32'h6666_6666;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            check_val("wd.wait_stall", 32'(bus.stall), 32'd1);
            check_val("wd.wait_err", 32'(err), 32'd0);
        end
        tick();
`ifdef MDU_WATCHDOG_TIMEOUT_EN
        check_val("wd.err_set", 32'(err), 32'd1);
        check_val("wd.ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check_val("wd.hi_kept", bus.rd_data, 32'hA5A5_A5A5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("wd.err_sticky", 32'(err), 32'd1);
        end
`else
        for (int k = 0; k < 4; k++) begin
            check_val("wd.no_abort_stall", 32'(bus.stall), 32'd1);
            check_val("wd.no_abort_err", 32'(err), 32'd0);
            tick();
        end
`endif
        reset        = 1'b1;
        bus.mdu_busy = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_val("wd.err_clear", 32'(err), 32'd0);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        check_val("wd.idle_ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which is the maximum number of WAIT cycles before a watchdog abort.
REQ-002 SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit, indicating an E-stage MDU-class instruction is present.
REQ-005 SHALL have port req_op, input, 4 bits, encoded 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=mfhi, 8=mflo; all other codes are ignored.
REQ-006 SHALL have ports req_a and req_b, input, 32 bits each, carrying the rs and rt operand values.
REQ-007 SHALL have port req_ready, output, 1 bit, indicating the request is accepted this cycle.
REQ-008 SHALL have port stall, output, 1 bit, equal to req_valid and not req_ready (pipeline freeze).
REQ-009 SHALL have port mdu_start, output, 1 bit, a one-cycle issue pulse to the multicycle unit.
REQ-010 SHALL have port mdu_op, output, 2 bits, encoded 0=mult, 1=multu, 2=div, 3=divu.
REQ-011 SHALL have ports mdu_a and mdu_b, output, 32 bits each, carrying the latched operands.
REQ-012 SHALL have port mdu_busy, input, 1 bit, the unit's busy flag.
REQ-013 SHALL have ports mdu_hi and mdu_lo, input, 32 bits each, carrying the unit's results.
REQ-014 SHALL have port rd_data, output, 32 bits, returning the mfhi/mflo result.
REQ-015 SHALL have port rd_valid, output, 1 bit, qualifying rd_data for one cycle.
REQ-016 SHALL have port err, output, 1 bit, a sticky watchdog-abort flag.

Function
REQ-017 SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-018 In IDLE with req_valid and op 1-4, SHALL assert req_ready, latch operands and op into mdu_a/mdu_b/mdu_op, and go to ISSUE.
REQ-019 In ISSUE, SHALL assert mdu_start for exactly one cycle, hold req_ready low, and go to WAIT.
REQ-020 In WAIT, SHALL stay while mdu_busy=1; on the first cycle with mdu_busy=0, SHALL capture mdu_hi/mdu_lo into shadow hi_q/lo_q and go to IDLE.
REQ-021 The WAIT-exit check SHALL not occur until at least one WAIT cycle has elapsed, which tolerates mdu_busy rising one cycle after mdu_start.
REQ-022 mthi/mtlo (op 5/6) in IDLE SHALL be accepted immediately and write req_a into hi_q/lo_q on the next edge, without pulsing mdu_start.
REQ-023 mfhi/mflo (op 7/8) in IDLE SHALL be accepted immediately; the following cycle SHALL present rd_data=hi_q/lo_q with rd_valid=1.
REQ-024 While in ISSUE or WAIT, req_ready SHALL be 0 for every op, so stall=1 whenever req_valid=1.
REQ-025 Ignored op codes with req_valid=1 SHALL get req_ready=1 and SHALL cause no state change.
REQ-026 Back-to-back ops: a mult or div accepted on the cycle WAIT returns to IDLE SHALL not occur; acceptance SHALL be earliest on the IDLE cycle.
REQ-027 mdu_a, mdu_b and mdu_op SHALL remain stable from ISSUE until the next acceptance.
REQ-028 An mthi/mtlo shadow write and a WAIT-completion capture SHALL never coincide, because of REQ-024.

Reset
REQ-029 On reset, SHALL set state=IDLE, mdu_start=0, rd_valid=0, err=0, and hi_q, lo_q, rd_data, mdu_a, mdu_b and mdu_op all to 0.
REQ-030 Reset during ISSUE or WAIT SHALL abandon the operation without capturing results.
REQ-031 req_ready SHALL be 0 while reset=1.

Configuration
REQ-032 With macro MDU_WATCHDOG_TIMEOUT_EN defined, SHALL count WAIT cycles; when the count reaches TIMEOUT with mdu_busy=1, SHALL set err=1, leave hi_q/lo_q unchanged and go to IDLE.
REQ-033 With MDU_WATCHDOG_TIMEOUT_EN undefined, SHALL include no counter, SHALL wait indefinitely, and err SHALL be tied to 0.

Verification
REQ-034 mult with a=0xFFFFFFFE, b=3, and the model busy for 5 cycles -> one mdu_start pulse, mdu_op=0, stall high throughout; after completion, mflo gives rd_data=0xFFFFFFFA and mfhi gives 0xFFFFFFFF.
REQ-035 divu with a=100, b=7, and busy for 10 cycles; mflo issued during WAIT -> stall=1 until IDLE, then rd_data=14 one cycle after acceptance.
REQ-036 mthi with a=0x12345678, then mfhi -> no mdu_start, and rd_data=0x12345678 on the cycle after the mfhi is accepted.
REQ-037 Reset asserted in the third WAIT cycle of a div -> state IDLE, hi_q=lo_q=0, and a later mfhi returns 0.
REQ-038 With the macro defined, TIMEOUT=16 and busy stuck high -> err=1 after 16 WAIT cycles, req_ready=1 on the next cycle, and err stays 1 until reset.
REQ-039 busy rising one cycle late after mdu_start -> the controller does not exit WAIT early, and the result is captured correctly.
